// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: number formats and saturation limits for fp_mul.
// Shared by fp_mul and its fx_resize instances.
package fp_mul_pkg;

    localparam int NB_A    = 16;
    localparam int NBF_A   = 14;
    localparam int NB_B    = 12;
    localparam int NBF_B   = 11;
    localparam int NB_FR   = NB_A + NB_B;
    localparam int NBF_FR  = NBF_A + NBF_B;

    localparam int NB_OVF  = 12;
    localparam int NBF_OVF = 11;
    localparam int NB_SAT  = 11;
    localparam int NBF_SAT = 10;
    localparam int NB_RND  = 9;
    localparam int NBF_RND = 8;

    localparam logic [NB_SAT-1:0] SAT_MAX = 11'h3FF;
    localparam logic [NB_SAT-1:0] SAT_MIN = 11'h400;
    localparam logic [NB_RND-1:0] RND_MAX = 9'h0FF;
    localparam logic [NB_RND-1:0] RND_MIN = 9'h100;

endpackage

// File: rtl/fx_resize.sv
// fx_resize: combinational signed fixed-point requantiser.
// Drops fraction bits by floor or round-half-up, then wraps or saturates.
module fx_resize #(
    parameter int NB_IN   = 28,
    parameter int NBF_IN  = 25,
    parameter int NB_OUT  = 12,
    parameter int NBF_OUT = 11,
    parameter int ROUND   = 0,
    parameter int SAT     = 0,
    parameter logic [NB_OUT-1:0] MAX_V = {1'b0, {(NB_OUT-1){1'b1}}},
    parameter logic [NB_OUT-1:0] MIN_V = {1'b1, {(NB_OUT-1){1'b0}}}
) (
    input  logic [NB_IN-1:0]  i_x,
    output logic [NB_OUT-1:0] o_y
);

    localparam int NB_X = NB_IN + 1;
    localparam int SH   = NBF_IN - NBF_OUT;
    // One extra bit of headroom keeps the rounding add from wrapping.
    localparam logic signed [NB_X-1:0] HALF =
        (ROUND != 0) ? (NB_X'(1) << (SH - 1)) : '0;

    logic signed [NB_X-1:0]     w_ext;
    logic signed [NB_X-1:0]     w_add;
    logic signed [NB_X-1:0]     w_shr;
    logic [NB_X-NB_OUT:0]       w_top;
    logic                       w_ovf;

    assign w_ext = {i_x[NB_IN-1], i_x};
    assign w_add = w_ext + HALF;
    assign w_shr = w_add >>> SH;
    assign w_top = w_shr[NB_X-1:NB_OUT-1];
    assign w_ovf = !((&w_top) || !(|w_top));

    // Wrap by default; clamp to the format limits when saturating.
    always_comb begin
        o_y = w_shr[NB_OUT-1:0];
        if ((SAT != 0) && w_ovf) begin
            o_y = w_shr[NB_X-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/fp_mul.sv
// fp_mul: S(16,14) x S(12,11) multiplier with four registered quantisations.
// Define FPMUL_IN_REG_EN to add an input register stage (latency 2).
module fp_mul
    import fp_mul_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [NB_A-1:0]   i_A,
    input  logic [NB_B-1:0]   i_B,
    output logic [NB_FR-1:0]  o_mulFR,
    output logic [NB_OVF-1:0] o_mulS_trunc_ov,
    output logic [NB_SAT-1:0] o_mulS_trunc_sat,
    output logic [NB_RND-1:0] o_mulS_round_sat
);

    logic signed [NB_A-1:0]  w_a;
    logic signed [NB_B-1:0]  w_b;
    logic signed [NB_FR-1:0] w_ax;
    logic signed [NB_FR-1:0] w_bx;
    logic signed [NB_FR-1:0] w_p;
    logic [NB_OVF-1:0]       w_ov;
    logic [NB_SAT-1:0]       w_sat;
    logic [NB_RND-1:0]       w_rnd;

    logic [NB_FR-1:0]        r_fr;
    logic [NB_OVF-1:0]       r_ov;
    logic [NB_SAT-1:0]       r_sat;
    logic [NB_RND-1:0]       r_rnd;

`ifdef FPMUL_IN_REG_EN
    logic [NB_A-1:0] r_a;
    logic [NB_B-1:0] r_b;

    // Optional operand capture stage.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= i_A;
            r_b <= i_B;
        end
    end

    assign w_a = r_a;
    assign w_b = r_b;
`else
    assign w_a = i_A;
    assign w_b = i_B;
`endif

    // The 28-bit product is exact: its magnitude never exceeds 2^26.
    assign w_ax = {{NB_B{w_a[NB_A-1]}}, w_a};
    assign w_bx = {{NB_A{w_b[NB_B-1]}}, w_b};
    assign w_p  = w_ax * w_bx;

    fx_resize #(
        .NB_IN(NB_FR), .NBF_IN(NBF_FR),
        .NB_OUT(NB_OVF), .NBF_OUT(NBF_OVF),
        .ROUND(0), .SAT(0)
    ) u_ov (
        .i_x(w_p),
        .o_y(w_ov)
    );

    fx_resize #(
        .NB_IN(NB_FR), .NBF_IN(NBF_FR),
        .NB_OUT(NB_SAT), .NBF_OUT(NBF_SAT),
        .ROUND(0), .SAT(1),
        .MAX_V(SAT_MAX), .MIN_V(SAT_MIN)
    ) u_sat (
        .i_x(w_p),
        .o_y(w_sat)
    );

    fx_resize #(
        .NB_IN(NB_FR), .NBF_IN(NBF_FR),
        .NB_OUT(NB_RND), .NBF_OUT(NBF_RND),
        .ROUND(1), .SAT(1),
        .MAX_V(RND_MAX), .MIN_V(RND_MIN)
    ) u_rnd (
        .i_x(w_p),
        .o_y(w_rnd)
    );

    // Output register for all four results.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fr  <= '0;
            r_ov  <= '0;
            r_sat <= '0;
            r_rnd <= '0;
        end else begin
            r_fr  <= w_p;
            r_ov  <= w_ov;
            r_sat <= w_sat;
            r_rnd <= w_rnd;
        end
    end

    assign o_mulFR          = r_fr;
    assign o_mulS_trunc_ov  = r_ov;
    assign o_mulS_trunc_sat = r_sat;
    assign o_mulS_round_sat = r_rnd;

endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: random streaming plus directed vectors for fp_mul.
// Reference model uses plain integer arithmetic on the exact product.
module tb_fp_mul;

`ifdef FPMUL_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [11:0] b;
    logic [27:0] fr;
    logic [11:0] ov;
    logic [10:0] sat;
    logic [8:0]  rnd;

    int n_pass;
    int n_tot;

    typedef struct {
        logic [15:0] a;
        logic [11:0] b;
        logic        v;
    } in_t;

    typedef struct {
        logic [27:0] fr;
        logic [11:0] ov;
        logic [10:0] sat;
        logic [8:0]  rnd;
    } res_t;

    in_t q[$];

    fp_mul dut (
        .clk(clk),
        .i_rst_n(rst_n),
        .i_A(a),
        .i_B(b),
        .o_mulFR(fr),
        .o_mulS_trunc_ov(ov),
        .o_mulS_trunc_sat(sat),
        .o_mulS_round_sat(rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(logic [15:0] xa, logic [11:0] xb);
        res_t   r;
        longint p;
        longint t;
        p = longint'($signed(xa)) * longint'($signed(xb));
        r.fr = p[27:0];
        t = p >>> 14;
        r.ov = t[11:0];
        t = p >>> 15;
        if (t > 1023) t = 1023;
        if (t < -1024) t = -1024;
        r.sat = t[10:0];
        t = (p + 65536) >>> 17;
        if (t > 255) t = 255;
        if (t < -256) t = -256;
        r.rnd = t[8:0];
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(posedge clk) begin
        in_t e;
        e.a = a;
        e.b = b;
        e.v = rst_n;
        q.push_back(e);
        if (q.size() > LAT) void'(q.pop_front());
    end

    always @(negedge clk) begin
        res_t m;
        if (rst_n && q.size() == LAT && q[0].v) begin
            m = model(q[0].a, q[0].b);
            chk("stream_fr",  32'(fr),  32'(m.fr));
            chk("stream_ov",  32'(ov),  32'(m.ov));
            chk("stream_sat", 32'(sat), 32'(m.sat));
            chk("stream_rnd", 32'(rnd), 32'(m.rnd));
        end
    end

    logic [15:0] d_a   [6] = '{16'h4000, 16'h8000, 16'h7FFF,
                               16'h0040, 16'hFFC0, 16'h0000};
    logic [11:0] d_b   [6] = '{12'h400, 12'h800, 12'h800,
                               12'h400, 12'h400, 12'h7FF};
    logic [27:0] d_fr  [6] = '{28'h1000000, 28'h4000000, 28'hC000800,
                               28'h0010000, 28'hFFF0000, 28'h0000000};
    logic [11:0] d_ov  [6] = '{12'h400, 12'h000, 12'h000,
                               12'h004, 12'hFFC, 12'h000};
    logic [10:0] d_sat [6] = '{11'h200, 11'h3FF, 11'h400,
                               11'h002, 11'h7FE, 11'h000};
    logic [8:0]  d_rnd [6] = '{9'h080, 9'h0FF, 9'h100,
                               9'h001, 9'h000, 9'h000};

    initial begin
        res_t m;
        n_pass = 0;
        n_tot  = 0;
        rst_n  = 1'b0;
        a      = 16'h1234;
        b      = 12'h567;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fr",  32'(fr),  32'h0);
        chk("rst_ov",  32'(ov),  32'h0);
        chk("rst_sat", 32'(sat), 32'h0);
        chk("rst_rnd", 32'(rnd), 32'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        m = model(16'h1234, 12'h567);
        chk("first_fr", 32'(fr), 32'(m.fr));

        for (int i = 0; i < 6; i++) begin
            m = model(d_a[i], d_b[i]);
            chk($sformatf("model_fr%0d", i),  32'(m.fr),  32'(d_fr[i]));
            chk($sformatf("model_ov%0d", i),  32'(m.ov),  32'(d_ov[i]));
            chk($sformatf("model_sat%0d", i), 32'(m.sat), 32'(d_sat[i]));
            chk($sformatf("model_rnd%0d", i), 32'(m.rnd), 32'(d_rnd[i]));
            @(posedge clk);
            #1;
            a = d_a[i];
            b = d_b[i];
            repeat (LAT) @(posedge clk);
            @(negedge clk);
            chk($sformatf("dir_fr%0d", i),  32'(fr),  32'(d_fr[i]));
            chk($sformatf("dir_ov%0d", i),  32'(ov),  32'(d_ov[i]));
            chk($sformatf("dir_sat%0d", i), 32'(sat), 32'(d_sat[i]));
            chk($sformatf("dir_rnd%0d", i), 32'(rnd), 32'(d_rnd[i]));
        end

        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            case ($urandom_range(0, 7))
                0: begin a = 16'h8000; b = 12'h800; end
                1: begin a = 16'h7FFF; b = 12'h800; end
                2: begin a = 16'h8000; b = 12'h7FF; end
                default: begin
                    a = 16'($urandom);
                    b = 12'($urandom);
                end
            endcase
        end

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_fr",  32'(fr),  32'h0);
        chk("arst_ov",  32'(ov),  32'h0);
        chk("arst_sat", 32'(sat), 32'h0);
        chk("arst_rnd", 32'(rnd), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fp_mul.md
Name: fp_mul

Overview:
- Signed fixed-point multiplier: A in S(16,14) times B in S(12,11).
- Produces four results from one product:
  - the full-resolution product;
  - a wrap-around truncated result, S(12,11);
  - a saturated truncated result, S(11,10);
  - a saturated rounded result, S(9,8).
- Used as a datapath arithmetic stage for comparing quantisation strategies against a bit-exact software model.
- All outputs are registered.

Parameters:
- NB_A, 16, total bits of i_A
- NBF_A, 14, fractional bits of i_A
- NB_B, 12, total bits of i_B
- NBF_B, 11, fractional bits of i_B
- NB_FR, 28 (= NB_A+NB_B), full-product width; fractional bits NBF_FR = NBF_A+NBF_B = 25
- NB_OVF, 12, NBF_OVF 11: wrap-truncate output format
- NB_SAT, 11, NBF_SAT 10: saturate-truncate output format
- NB_RND, 9, NBF_RND 8: saturate-round output format

Ports:
- clk  in  1  system clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_A  in  NB_A  signed operand A, S(16,14), range [-2, 2)
- i_B  in  NB_B  signed operand B, S(12,11), range [-1, 1)
- o_mulFR  out  NB_FR  full product, S(28,25), exact
- o_mulS_trunc_ov  out  NB_OVF  product truncated, with overflow wrap, S(12,11)
- o_mulS_trunc_sat  out  NB_SAT  product truncated, with saturation, S(11,10)
- o_mulS_round_sat  out  NB_RND  product rounded, with saturation, S(9,8)

Behaviour:
- Reset: i_rst_n=0 forces all outputs to 0 immediately (async); outputs are released on the first rising clk after deassertion.
- Product: P = signed(i_A) * signed(i_B), 28 bits, 25 fractional bits.
  - Range (-2, +2]; the extreme case +2.0 = 2^26 fits the 28-bit width, so the product never overflows.
- Latency: 1 cycle. Inputs are sampled on rising clk and the registered outputs present the result after that edge.
  - There is no handshake; a new operand pair is accepted every cycle.
- o_mulFR = P.
- o_mulS_trunc_ov = P[25:14].
  - Discards 14 LSBs and the 2 MSBs (wraps); no saturation.
- o_mulS_trunc_sat = saturate(P >>> 15) to 11 bits.
  - If P[27:25] are not all equal: P>0 gives 11'h3FF, P<0 gives 11'h400.
  - Otherwise the result is P[25:15].
  - Truncation is floor, toward -inf.
- o_mulS_round_sat:
  - Compute R = (sign-extended P to 29 bits + 2^16) >>> 17, i.e. round half up toward +inf.
  - Saturate R to 9 bits: R > 255 gives 9'h0FF, R < -256 gives 9'h100.
  - Saturation is applied after the rounding add, so a round carry into overflow saturates.
- Intermediates are computed sign-extended so the +2^16 add never wraps.
- Saturation detection is combinational before the output register.

Optional Feature:
- FPMUL_IN_REG_EN defined: adds an input register stage on i_A/i_B (reset to 0).
  - Total latency becomes 2 cycles; all outputs stay aligned.
- Undefined: 1-cycle latency as above.

Decomposition:
- Package fp_mul_pkg holds the format localparams (NB_*/NBF_*) and the saturation limit constants.
- One natural sub-module, fx_resize:
  - parameterised NB_IN/NBF_IN/NB_OUT/NBF_OUT, plus selects ROUND (0/1) and SAT (0/1);
  - combinational;
  - instantiated three times on P, once per quantised output.

Test Plan:
- Reset: i_rst_n=0 with nonzero inputs and clock running -> all four outputs 0. After release, the first result appears one edge later.
- A=16'h4000 (1.0), B=12'h400 (0.5) -> FR=28'h1000000, ov=12'h400, sat=11'h200, rnd=9'h080.
- A=16'h8000 (-2), B=12'h800 (-1) -> FR=28'h4000000 (+2), ov=12'h000 (wraps), sat=11'h3FF, rnd=9'h0FF.
- A=16'h7FFF, B=12'h800 -> FR=28'hC000800, ov=12'h000, sat=11'h400, rnd=9'h100 (negative saturation).
- Rounding tie:
  - A=16'h0040, B=12'h400 (P=2^16) -> ov=12'h004, sat=11'h002, rnd=9'h001.
  - A=16'hFFC0, B=12'h400 (P=-2^16) -> ov=12'hFFC, sat=11'h7FE, rnd=9'h000.
- Streaming: 1000 random pairs, one per cycle -> every output matches the bit-exact software model delayed by 1 cycle (2 with FPMUL_IN_REG_EN).
